uart_txrx: RTL and testbench
============================

Name: uart_txrx

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver sharing one clock and reset.
- Sits between the pipelined core's I/O unit and the board serial pins.
- Used on the host/loader side for program and data download (0xAA handshake byte) and result upload.
- Bit timing is set by a single half-bit clock count; no baud generator outside the block.

Parameters:
- CLK_PER_HALF_BIT, 30: clk cycles per half bit period. Full bit = 2*CLK_PER_HALF_BIT cycles. Legal range is 2 or more.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- sdata  in  8  byte to transmit; sampled on the accepted tx_start
- tx_start  in  1  transmit request; accepted only when tx_busy=0
- tx_busy  out  1  high while a frame is being sent
- txd  out  1  serial output; idle high
- rxd  in  1  serial input; asynchronous; idle high
- rdata  out  8  last correctly received byte; held until the next good frame
- rdata_ready  out  1  one-cycle pulse when rdata is updated
- ferr  out  1  one-cycle pulse when a stop bit is sampled low

Behaviour:
- Reset (reset=0 at a rising edge): txd=1, tx_busy=0, rdata=0x00, rdata_ready=0, ferr=0.
  - Both FSMs return to IDLE; any frame in progress is aborted.
  - Reset has priority over every other input.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly B = 2*CLK_PER_HALF_BIT cycles.
- TX FSM states:
  - IDLE: txd=1, tx_busy=0. Edge with tx_start=1 -> latch sdata, go to START.
  - START: from the next cycle txd=0 and tx_busy=1 for B cycles -> DATA.
  - DATA: bits 0..7, B cycles each, txd = sdata_latched[i] -> STOP.
  - STOP: txd=1 for B cycles -> IDLE. tx_busy=0 in the cycle after STOP ends.
  - tx_busy is high for exactly 10*B cycles per frame.
  - tx_start while busy is ignored; it is not queued.
  - sdata changes after acceptance do not affect the frame.
- RX input: 2-flop synchronizer on rxd. All RX timing is referenced to the synchronized signal.
- RX FSM states:
  - IDLE: wait for synchronized rxd = 0 -> START.
  - START: count CLK_PER_HALF_BIT cycles, then sample. If the sample is 1 (glitch), return to IDLE with no outputs. If 0 -> DATA.
  - DATA: sample every B cycles (mid-bit). Shift LSB-first into a shift register; 8 samples -> STOP.
  - STOP: sample after B cycles.
    - Sample 1: rdata <= shift register, rdata_ready=1 for one cycle.
    - Sample 0: ferr=1 for one cycle; rdata unchanged, no rdata_ready.
    - Either way -> IDLE.
- RX IDLE re-arms immediately after the stop-bit sample, so back-to-back frames are received. A receiver in IDLE waits for a new falling level, so no false start on a held-high line.
- A start glitch shorter than CLK_PER_HALF_BIT cycles produces no output.
- Reception latency: rdata_ready occurs at synchronized start edge + CLK_PER_HALF_BIT + 9*B cycles, within +-1 cycle.
- TX and RX are fully independent; simultaneous activity is legal.
- Internal counters are wide enough for 2*CLK_PER_HALF_BIT (clog2). There are no wrap-around cases inside a bit.

Decomposition:
- Package uart_pkg holds:
  - frame constants: DATA_BITS=8, START_BIT=0, STOP_BIT=1;
  - TX and RX state enums (IDLE/START/DATA/STOP).
- Natural sub-modules: uart_tx_core (TX FSM) and uart_rx_core (synchronizer plus RX FSM), instantiated side by side in uart_txrx.
- The shared bit counter/timer is small enough to stay inline in each.

Test Plan:
- Loopback (txd tied to rxd), CLK_PER_HALF_BIT=30, send sdata=0xAA -> exactly one rdata_ready pulse, rdata=0xAA, ferr never high. tx_busy high for 600 cycles.
- TX waveform, sdata=0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each level held 60 cycles. txd=1 afterwards.
- tx_start pulsed again 100 cycles into a frame with sdata=0xFF -> ignored. The frame still carries the first byte, and only 600 busy cycles occur.
- Drive rxd with 0x3C but stop bit 0 -> one ferr pulse, no rdata_ready, rdata keeps the previous value.
- rxd low for 10 cycles then high -> no rdata_ready, no ferr. A following valid 0x12 frame is received correctly.
- reset=0 mid-TX frame -> next cycle txd=1 and tx_busy=0. A new tx_start after release sends a full, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared frame constants and FSM state types for the 8N1 UART transmitter and receiver.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Width of a counter that must reach one full bit period minus one.
  function automatic int cnt_width(input int half_bit);
    return $clog2(2 * half_bit);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling, good-byte and framing-error pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_ready,
  output logic                 ferr
);

  localparam int            CW        = cnt_width(CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  rx_state_t              r_state;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_rdata;
  logic                   r_ready;
  logic                   r_ferr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // START waits half a bit so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_sync2 == START_BIT) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= (r_sync2 == START_BIT) ? RX_DATA : RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == IDX_LAST) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync2 == STOP_BIT) begin
              r_rdata <= r_shift;
              r_ready <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign rdata_ready = r_ready;
  assign ferr        = r_ferr;

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 transmitter: latches the byte on an accepted request and shifts it out LSB first.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] sdata,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 txd
);

  localparam int            CW       = cnt_width(CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t              r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_idx;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_txd;
  logic                   r_busy;
  logic                   w_bit_end;

  assign w_bit_end = (r_cnt == BIT_LAST);

  // r_data is shifted right each bit, so r_data[1] is the next bit to drive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_txd   <= STOP_BIT;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_txd  <= STOP_BIT;
          r_busy <= 1'b0;
          r_cnt  <= '0;
          if (tx_start) begin
            r_data  <= sdata;
            r_txd   <= START_BIT;
            r_busy  <= 1'b1;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= r_data[0];
            r_state <= TX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == IDX_LAST) begin
              r_txd   <= STOP_BIT;
              r_state <= TX_STOP;
            end else begin
              r_idx  <= r_idx + 1'b1;
              r_data <= {1'b0, r_data[DATA_BITS-1:1]};
              r_txd  <= r_data[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign txd     = r_txd;
  assign tx_busy = r_busy;

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART between the core I/O unit and the board serial pins.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] sdata,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_ready,
  output logic                 ferr
);

  uart_tx_core #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .sdata    (sdata),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .txd      (txd)
  );

  uart_rx_core #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed-vector bench for uart_txrx: TX frames checked bit by bit in loopback, RX frames driven by hand.
module tb_uart_txrx;

  localparam int CPH = 30;
  localparam int B   = 2 * CPH;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sdata = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy;
  logic       txd;
  logic       rxd;
  logic [7:0] rdata;
  logic       rdata_ready;
  logic       ferr;

  logic       loop_en = 1'b1;
  logic       rxd_drv = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int ready_cnt = 0;
  int ferr_cnt = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_txrx #(.CLK_PER_HALF_BIT(CPH)) dut (
    .clk         (clk),
    .reset       (reset),
    .sdata       (sdata),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .txd         (txd),
    .rxd         (rxd),
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr)
  );

  always @(negedge clk) begin
    if (tx_busy)     busy_cnt  <= busy_cnt + 1;
    if (rdata_ready) ready_cnt <= ready_cnt + 1;
    if (ferr)        ferr_cnt  <= ferr_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    bit         retrig;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_ready;
    int         exp_ferr;
    logic [7:0] exp_rdata;
  } rx_vec_t;

  tx_vec_t tx_tab[6];
  rx_vec_t rx_tab[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Sends one byte in loopback; txd is sampled mid-bit and the echo is checked on rdata.
  task automatic do_tx(input logic [7:0] d, input logic [9:0] frame, input bit retrig);
    int b0, r0, f0;
    b0 = busy_cnt;
    r0 = ready_cnt;
    f0 = ferr_cnt;
    @(negedge clk);
    sdata = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    sdata = ~d;
    if (retrig) begin
      fork
        begin
          repeat (99) @(negedge clk);
          sdata = 8'hFF;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
        end
      join_none
    end
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? B / 2 : B) @(negedge clk);
      chk($sformatf("txd_bit%0d_%02h", k, d), 32'(txd), 32'(frame[k]));
    end
    repeat (B) @(negedge clk);
    chk("busy_cycles", 32'(busy_cnt - b0), 32'(10 * B));
    chk("busy_after", 32'(tx_busy), 32'd0);
    chk("txd_idle", 32'(txd), 32'd1);
    chk("loop_ready_cnt", 32'(ready_cnt - r0), 32'd1);
    chk("loop_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
    chk("loop_rdata", 32'(rdata), 32'(d));
    $display("tx data=%02h retrig=%0d rdata=%02h busy=%0d", d, retrig, rdata, busy_cnt - b0);
  endtask

  task automatic rx_frame(input rx_vec_t v);
    int r0, f0;
    r0 = ready_cnt;
    f0 = ferr_cnt;
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = v.data[i];
      repeat (B) @(negedge clk);
    end
    rxd_drv = v.stop;
    repeat (B) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (B) @(negedge clk);
    chk($sformatf("rx_ready_%02h", v.data), 32'(ready_cnt - r0), 32'(v.exp_ready));
    chk($sformatf("rx_ferr_%02h", v.data), 32'(ferr_cnt - f0), 32'(v.exp_ferr));
    chk($sformatf("rx_rdata_%02h", v.data), 32'(rdata), 32'(v.exp_rdata));
    $display("rx data=%02h stop=%0d rdata=%02h ready=%0d ferr=%0d",
             v.data, v.stop, rdata, ready_cnt - r0, ferr_cnt - f0);
  endtask

  initial begin
    int r0, f0;

    tx_tab[0] = '{data: 8'hAA, frame: 10'b1101010100, retrig: 1'b0};
    tx_tab[1] = '{data: 8'h55, frame: 10'b1010101010, retrig: 1'b0};
    tx_tab[2] = '{data: 8'h00, frame: 10'b1000000000, retrig: 1'b0};
    tx_tab[3] = '{data: 8'hFF, frame: 10'b1111111110, retrig: 1'b0};
    tx_tab[4] = '{data: 8'h81, frame: 10'b1100000010, retrig: 1'b0};
    tx_tab[5] = '{data: 8'hA5, frame: 10'b1101001010, retrig: 1'b1};

    rx_tab[0] = '{data: 8'h12, stop: 1'b1, exp_ready: 1, exp_ferr: 0, exp_rdata: 8'h12};
    rx_tab[1] = '{data: 8'h3C, stop: 1'b0, exp_ready: 0, exp_ferr: 1, exp_rdata: 8'h12};
    rx_tab[2] = '{data: 8'hC3, stop: 1'b1, exp_ready: 1, exp_ferr: 0, exp_rdata: 8'hC3};
    rx_tab[3] = '{data: 8'h00, stop: 1'b1, exp_ready: 1, exp_ferr: 0, exp_rdata: 8'h00};
    rx_tab[4] = '{data: 8'hFE, stop: 1'b1, exp_ready: 1, exp_ferr: 0, exp_rdata: 8'hFE};

    repeat (4) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_ready", 32'(rdata_ready), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_tx(tx_tab[i].data, tx_tab[i].frame, tx_tab[i].retrig);
    end

    // Reset in the middle of a frame must force the line idle on the next edge.
    @(negedge clk);
    sdata = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (200) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (B) @(negedge clk);
    do_tx(8'h96, 10'b1100101100, 1'b0);

    loop_en = 1'b0;
    rxd_drv = 1'b1;
    repeat (B) @(negedge clk);

    // A 10-cycle low pulse is shorter than half a bit and must be ignored.
    r0 = ready_cnt;
    f0 = ferr_cnt;
    rxd_drv = 1'b0;
    repeat (10) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2 * B) @(negedge clk);
    chk("glitch_ready", 32'(ready_cnt - r0), 32'd0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    $display("rx glitch 10 cycles ready=%0d ferr=%0d", ready_cnt - r0, ferr_cnt - f0);

    for (int i = 0; i < 5; i++) begin
      rx_frame(rx_tab[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
